// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V execute/fetch-address slice.
package riscv_pkg;

    localparam int XLEN    = 64;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/pc_alu_datapath_if.sv
// Control/operand bundle between the processor top and the PC/ALU slice.
// There is no handshake: every output is a same-cycle combinational view of the inputs and pc.
interface pc_alu_datapath_if
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
);

    logic                branch;
    logic                alu_src;
    alu_op_t             alu_op;
    logic [WIDTH-1:0]    rs1_data;
    logic [WIDTH-1:0]    rs2_data;
    logic [WIDTH-1:0]    imm;

    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    pc_plus4;
    logic [WIDTH-1:0]    branch_target;
    logic [WIDTH-1:0]    alu_result;
    logic                zero;
    logic                take_branch;

    modport master (
        output branch, alu_src, alu_op, rs1_data, rs2_data, imm,
        input  pc, pc_plus4, branch_target, alu_result, zero, take_branch
    );

    modport slave (
        input  branch, alu_src, alu_op, rs1_data, rs2_data, imm,
        output pc, pc_plus4, branch_target, alu_result, zero, take_branch
    );

endinterface

// File: rtl/pc_alu_datapath_alu_core.sv
// Combinational ALU (ADD/SUB/AND/OR, wrap-around) with a zero flag.
module alu_core
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end

    // Zero is reported for every op, not only SUB.
    assign zero_o = (result_o == '0);

endmodule

// File: rtl/pc_alu_datapath.sv
// PC register, PC+step and branch-target adders, ALU and next-PC select.
module pc_alu_datapath
    import riscv_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               PC_STEP  = riscv_pkg::PC_STEP,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               pc_reset,
    pc_alu_datapath_if.slave   dp
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus_step;
    logic [WIDTH-1:0] imm_shl;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic             take_branch;

    assign pc_plus_step = pc_q + WIDTH'(PC_STEP);

    // Offset is counted in halfwords: the imm MSB falls off and the base is pc, not pc+step.
    assign imm_shl = {dp.imm[WIDTH-2:0], 1'b0};
    assign target  = pc_q + imm_shl;

    assign operand_b = dp.alu_src ? dp.imm : dp.rs2_data;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a_i      (dp.rs1_data),
        .b_i      (operand_b),
        .op_i     (dp.alu_op),
        .result_o (alu_result),
        .zero_o   (zero)
    );

    assign take_branch = zero & dp.branch;
    assign pc_d        = take_branch ? target : pc_plus_step;

    // Reset wins over a taken branch in the same cycle.
    always_ff @(posedge clk) begin
        if (pc_reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign dp.pc            = pc_q;
    assign dp.pc_plus4      = pc_plus_step;
    assign dp.branch_target = target;
    assign dp.alu_result    = alu_result;
    assign dp.zero          = zero;
    assign dp.take_branch   = take_branch;

endmodule

// File: tb/tb_pc_alu_datapath.sv
// Directed-vector bench for pc_alu_datapath with an expected-response queue and negedge monitor.
module tb_pc_alu_datapath;
  import riscv_pkg::*;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] branch_target;
    logic [W-1:0] alu_result;
    logic         zero;
    logic         take_branch;
  } exp_t;

  logic clk;
  logic pc_reset;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  exp_t mon_e;

  pc_alu_datapath_if #(.WIDTH(W)) dp ();

  pc_alu_datapath #(
    .WIDTH    (W),
    .PC_STEP  (4),
    .RESET_PC ('0)
  ) dut (
    .clk      (clk),
    .pc_reset (pc_reset),
    .dp       (dp.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver
  function automatic exp_t mk(input logic [W-1:0] pc, input logic [W-1:0] p4,
                              input logic [W-1:0] bt, input logic [W-1:0] alu,
                              input logic z, input logic tb);
    exp_t e;
    e.pc = pc; e.pc_plus4 = p4; e.branch_target = bt;
    e.alu_result = alu; e.zero = z; e.take_branch = tb;
    return e;
  endfunction

  task automatic drive(input logic rst, input logic br, input logic src, input alu_op_t op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] im,
                       input exp_t e);
    @(posedge clk);
    #1;
    pc_reset    = rst;
    dp.branch   = br;
    dp.alu_src  = src;
    dp.alu_op   = op;
    dp.rs1_data = a;
    dp.rs2_data = b;
    dp.imm      = im;
    exp_q.push_back(e);
  endtask

  // scoreboard
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("pc",            dp.pc,                    mon_e.pc);
      check("pc_plus4",      dp.pc_plus4,              mon_e.pc_plus4);
      check("branch_target", dp.branch_target,         mon_e.branch_target);
      check("alu_result",    dp.alu_result,            mon_e.alu_result);
      check("zero",          {{(W-1){1'b0}}, dp.zero},        {{(W-1){1'b0}}, mon_e.zero});
      check("take_branch",   {{(W-1){1'b0}}, dp.take_branch}, {{(W-1){1'b0}}, mon_e.take_branch});
    end
  end

  initial begin
    #50000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, %0d responses pending", exp_q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // stimulus
  initial begin
    int wait_cnt;
    n_tests     = 0;
    n_fail      = 0;
    pc_reset    = 1'b1;
    dp.branch   = 1'b0;
    dp.alu_src  = 1'b0;
    dp.alu_op   = ALU_ADD;
    dp.rs1_data = '0;
    dp.rs2_data = '0;
    dp.imm      = '0;

    // reset held for two edges, then sequential count and ALU ops
    drive(1, 0, 0, ALU_ADD, 64'd0, 64'd0, 64'd0, mk(64'd0, 64'd4, 64'd0, 64'd0, 1, 0));
    drive(0, 0, 0, ALU_ADD, 64'd7, 64'd5, 64'd0, mk(64'd0, 64'd4, 64'd0, 64'd12, 0, 0));
    drive(0, 0, 0, ALU_SUB, 64'd7, 64'd5, 64'd0, mk(64'd4, 64'd8, 64'd4, 64'd2, 0, 0));
    drive(0, 0, 0, ALU_AND, 64'd7, 64'd5, 64'd0, mk(64'd8, 64'd12, 64'd8, 64'd5, 0, 0));
    drive(0, 0, 0, ALU_OR,  64'd7, 64'd5, 64'd0, mk(64'd12, 64'd16, 64'd12, 64'd7, 0, 0));
    drive(0, 0, 0, ALU_SUB, 64'h1234, 64'h1234, 64'd0, mk(64'd16, 64'd20, 64'd16, 64'd0, 1, 0));
    drive(0, 0, 1, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1,
          mk(64'd20, 64'd24, 64'd22, 64'd0, 1, 0));

    // re-reset mid-run, then walk to pc=8
    drive(1, 0, 0, ALU_ADD, 64'd0, 64'd0, 64'd0, mk(64'd24, 64'd28, 64'd24, 64'd0, 1, 0));
    drive(0, 0, 0, ALU_ADD, 64'd0, 64'd0, 64'd0, mk(64'd0, 64'd4, 64'd0, 64'd0, 1, 0));
    drive(0, 0, 0, ALU_ADD, 64'd0, 64'd0, 64'd0, mk(64'd4, 64'd8, 64'd4, 64'd0, 1, 0));

    // taken branch, negative offset, not-taken branch, branch to 40
    drive(0, 1, 0, ALU_SUB, 64'd3, 64'd3, 64'd6, mk(64'd8, 64'd12, 64'd20, 64'd0, 1, 1));
    drive(0, 1, 0, ALU_SUB, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC,
          mk(64'd20, 64'd24, 64'd12, 64'd0, 1, 1));
    drive(0, 1, 0, ALU_SUB, 64'd5, 64'd3, 64'd6, mk(64'd12, 64'd16, 64'd24, 64'd2, 0, 0));
    drive(0, 1, 0, ALU_SUB, 64'd9, 64'd9, 64'd12, mk(64'd16, 64'd20, 64'd40, 64'd0, 1, 1));

    // reset beats a taken branch at pc=40
    drive(1, 1, 0, ALU_SUB, 64'd9, 64'd9, 64'd6, mk(64'd40, 64'd44, 64'd52, 64'd0, 1, 1));

    // branch to 2^64-4, then wrap; imm MSB must drop out of the shift
    drive(0, 1, 0, ALU_SUB, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE,
          mk(64'd0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1, 1));
    drive(0, 0, 0, ALU_OR, 64'd1, 64'd2, 64'h8000_0000_0000_0001,
          mk(64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0, 0));
    drive(0, 0, 0, ALU_ADD, 64'd0, 64'd0, 64'd0, mk(64'd0, 64'd4, 64'd0, 64'd0, 1, 0));

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 8) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses still queued, expected 0", exp_q.size());
    end

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_alu_datapath.md
Name: pc_alu_datapath

Overview:
- Single-cycle RISC-V execute/fetch-address slice. Contains:
  - the program-counter register;
  - the PC+4 incrementer and the branch-target adder;
  - the ALU with operand-B select and zero flag;
  - the next-PC branch select.
- Sits between the instruction memory address (pc output) and the register bank, control unit, immediate generator and data memory in the processor top.
- The clock is generated externally and enters as an input.

Parameters:
- WIDTH, 64, datapath/PC width in bits.
- PC_STEP, 4, sequential increment added to PC each cycle.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- pc_reset  input  1  synchronous, active-high reset.
- branch  input  1  control: current instruction is a conditional branch.
- alu_src  input  1  0 selects rs2_data as ALU operand B; 1 selects imm.
- alu_op  input  2  ALU operation select.
- rs1_data  input  WIDTH  ALU operand A.
- rs2_data  input  WIDTH  register operand B.
- imm  input  WIDTH  sign-extended immediate from immediate generator.
- pc  output  WIDTH  current PC; instruction memory indexes with pc[WIDTH-1:2].
- pc_plus4  output  WIDTH  pc + PC_STEP.
- branch_target  output  WIDTH  pc + (imm << 1).
- alu_result  output  WIDTH  ALU result; data memory address and write-back data.
- zero  output  1  1 when alu_result == 0.
- take_branch  output  1  zero & branch.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset pc_reset is synchronous and active-high.
  - At a rising edge with pc_reset=1: pc <= RESET_PC.
  - Otherwise at a rising edge: pc <= next_pc.
  - pc holds RESET_PC for every edge on which reset is sampled high. The top asserts reset for the first 2 edges.
- Next PC: next_pc = take_branch ? branch_target : pc_plus4.
- Adders:
  - WIDTH-bit unsigned addition; carry-out discarded; wraps modulo 2^WIDTH.
  - Example: pc = 2^64-4 gives pc_plus4 = 0.
- Branch target:
  - The shift is a logical left shift by 1 of imm; bit WIDTH-1 of imm is dropped.
  - Added to the current pc, not to pc_plus4.
- ALU operand B: alu_src ? imm : rs2_data.
- ALU operations (combinational, wrap-around, no flags other than zero):
  - 00 ADD: a + b.
  - 01 SUB: a - b, two's complement.
  - 10 AND: a & b.
  - 11 OR: a | b.
- zero = (alu_result == 0), evaluated for every alu_op.
- take_branch = zero & branch. Branch is taken on equality when the control unit drives SUB (BEQ semantics).
- Timing:
  - All non-pc outputs are purely combinational from inputs and pc, valid in the same cycle.
  - No internal latency beyond the PC register.
- Reset vs. branch: reset has priority. A taken branch in the reset cycle is ignored and pc becomes RESET_PC.
- Reset mid-operation: on the next edge with pc_reset=1, pc returns to RESET_PC regardless of prior state.
- X-free: all outputs are defined once pc has been reset. No latches.

Decomposition:
- Shared package (riscv_pkg):
  - alu_op_t enum {ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11};
  - localparam XLEN=64;
  - localparam PC_STEP=4.
- One natural sub-module: alu_core (combinational ALU plus zero flag).
- Adders and muxes stay inline as continuous assignments.

Test Plan:
- Reset: pc_reset=1 for 2 edges, then 0, branch=0 → pc=0 during reset, then 4, 8, 12 on successive edges; pc_plus4 = pc+4.
- ALU ops (alu_src=0):
  - rs1=7, rs2=5: alu_op 00 → 12, 01 → 2, 10 → 5, 11 → 7; zero=0 throughout.
  - rs1=rs2=0x1234, alu_op=01 → alu_result=0, zero=1.
- Immediate select and wrap: alu_src=1, rs1=0xFFFF_FFFF_FFFF_FFFF, imm=1, ADD → alu_result=0, zero=1.
- Branch taken: pc=8, imm=6, branch=1, SUB with equal operands → branch_target=20, take_branch=1, next pc=20. Same stimulus with unequal operands → next pc=12.
- Negative offset: pc=20, imm=0xFFFF_FFFF_FFFF_FFFC (−4), taken → pc becomes 12.
- Reset priority: pc_reset=1 with take_branch=1 at pc=40 → pc=0 after the edge. PC wrap: pc=0xFFFF_FFFF_FFFF_FFFC, no branch → next pc=0.
